id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, 1 = forwarding muxes active, 0 = operands taken straight from registered values.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hold all stage registers.
REQ-005 flush  input  1  replace the next captured instruction with a bubble.
REQ-006 valid_in  input  1  decode stage holds a real instruction.
REQ-007 rd1_in, rd2_in, imm_in  input  32 each  register-file read data and sign-extended immediate.
REQ-008 rs_in, rt_in, rd_in  input  5 each  source and destination register numbers.
REQ-009 alucontrol_in  input  4  ALU function code, passed unchanged to the ALU f port.
REQ-010 alusrc_in, regdst_in, regwrite_in, memtoreg_in, memwrite_in  input  1 each  decoded controls.
REQ-011 exm_regwrite  input  1, exm_rd  input  5, exm_result  input  32  EX/MEM forwarding source.
REQ-012 mwb_regwrite  input  1, mwb_rd  input  5, mwb_result  input  32  MEM/WB forwarding source.
REQ-013 srca, srcb  output  32  ALU operands a and b.
REQ-014 alu_f  output  4  ALU function code.
REQ-015 writedata  output  32  forwarded rt value for stores.
REQ-016 writereg  output  5  destination register number.
REQ-017 regwrite_out, memtoreg_out, memwrite_out, valid_out  output  1 each  controls for the next stage.

Function
REQ-018 Registered fields SHALL be rd1, rd2, imm, rs, rt, rd, alucontrol, alusrc, regdst, regwrite, memtoreg, memwrite, valid, all captured on the rising clock edge.
REQ-019 If flush=1, the stage SHALL clear valid, regwrite, memwrite and memtoreg on the edge and hold all data fields; flush takes priority over stall.
REQ-020 If stall=1 and flush=0, every registered field SHALL hold its value.
REQ-021 Otherwise every field SHALL capture its input; a field captured with valid_in=0 SHALL force regwrite, memwrite and memtoreg to 0.
REQ-022 The latency from input to registered output SHALL be one cycle; srca, srcb and writedata SHALL be combinational from the registered fields and the forwarding inputs.
REQ-023 Forward selection for operand A using rs: if exm_regwrite=1, exm_rd=rs and rs!=0, the source SHALL be exm_result. Else if mwb_regwrite=1, mwb_rd=rs and rs!=0, the source SHALL be mwb_result. Else the source SHALL be the registered rd1.
REQ-024 The forwarded rt value SHALL use the same priority as REQ-023, applied to rt and rd2.
REQ-025 The stage SHALL drive srca = forwarded rs value, writedata = forwarded rt value, and srcb = imm when alusrc=1, else the forwarded rt value.
REQ-026 With FWD_EN=0, the stage SHALL ignore all exm_* and mwb_* inputs.
REQ-027 The stage SHALL drive writereg = rd when regdst=1, else rt.
REQ-028 The stage SHALL drive alu_f = registered alucontrol, unmodified.
REQ-029 Register 0 SHALL never be a forwarding match, even when a source writes with rd=0.
REQ-030 When both forwarding sources match, EX/MEM SHALL win.
REQ-031 Outputs for a bubble (valid_out=0) SHALL still be computed, but all write controls SHALL be 0.

Reset
REQ-032 While rst_n=0, all registered fields SHALL be 0 immediately, without waiting for clk; valid_out, the write controls, alu_f and writereg therefore read 0.
REQ-033 In reset, srca, srcb and writedata SHALL equal 0 unless forwarding inputs match register 0, which they never do (REQ-029).
REQ-034 Reset asserted mid-stall SHALL discard the held instruction.
REQ-035 On the first edge after rst_n rises, the stage SHALL capture normally.

Verification
REQ-036 Reset: rst_n=0 between edges -> all outputs 0 before the next edge; release and capture rd1=5, rs=3 -> srca=5 one cycle later.
REQ-037 Priority: rs=7, exm_regwrite=1, exm_rd=7, exm_result=0xAAAA0000, mwb_rd=7, mwb_regwrite=1 -> srca=0xAAAA0000; drop exm_regwrite -> srca=mwb_result.
REQ-038 Register 0 and immediate: rt=0, exm_rd=0, exm_regwrite=1 -> writedata=registered rd2; alusrc=1, imm=0xFFFFFFFC -> srcb=0xFFFFFFFC, writedata still forwarded rt.
REQ-039 Stall: stall=1 for 3 cycles while inputs change -> outputs unchanged; flush+stall together -> valid_out=0, regwrite_out=0 next cycle.
REQ-040 Bubble: valid_in=0 with regwrite_in=1, memwrite_in=1 -> regwrite_out=0, memwrite_out=0, valid_out=0.
REQ-041 FWD_EN=0 build: matching exm_rd -> srca=registered rd1.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with operand forwarding for a 5-stage MIPS-style
// pipeline. Decoded fields are captured on the rising clock edge; the ALU
// operands, store data and destination register are derived combinationally
// from the registered fields and the EX/MEM and MEM/WB forwarding sources.
//
// Parameters
//   FWD_EN        1 = forwarding muxes active, 0 = registered operands only
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   stall         hold every stage register
//   flush         turn the next captured instruction into a bubble
//   valid_in      decode stage holds a real instruction
//   rd1_in/rd2_in register-file read data, imm_in sign-extended immediate
//   rs_in/rt_in/rd_in  source and destination register numbers
//   alucontrol_in ALU function code
//   alusrc_in, regdst_in, regwrite_in, memtoreg_in, memwrite_in  controls
//   exm_*         EX/MEM forwarding source (regwrite, rd, result)
//   mwb_*         MEM/WB forwarding source (regwrite, rd, result)
//   srca, srcb    ALU operands
//   alu_f         ALU function code
//   writedata     forwarded rt value for stores
//   writereg      destination register number
//   regwrite_out, memtoreg_out, memwrite_out, valid_out  next-stage controls
module id_ex_stage #(
    parameter int FWD_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [31:0] rd1_in,
    input  logic [31:0] rd2_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [3:0]  alucontrol_in,
    input  logic        alusrc_in,
    input  logic        regdst_in,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic        memwrite_in,
    input  logic        exm_regwrite,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_regwrite,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic [31:0] srca,
    output logic [31:0] srcb,
    output logic [3:0]  alu_f,
    output logic [31:0] writedata,
    output logic [4:0]  writereg,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic        memwrite_out,
    output logic        valid_out
);

    logic [31:0] rd1_p0, rd2_p0, imm_p0;
    logic [4:0]  rs_p0, rt_p0, rd_p0;
    logic [3:0]  alucontrol_p0;
    logic        alusrc_p0, regdst_p0;
    logic        regwrite_p0, memtoreg_p0, memwrite_p0, vld_p0;
    logic [31:0] fwd_rs, fwd_rt;

    // EX/MEM beats MEM/WB; register 0 is hard-wired and never matches.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] regval,
        input logic        e_we,
        input logic [4:0]  e_rd,
        input logic [31:0] e_val,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_val
    );
        logic [31:0] r;
        r = regval;
        if (FWD_EN != 0 && src != 5'd0) begin
            if (e_we && e_rd == src)
                r = e_val;
            else if (m_we && m_rd == src)
                r = m_val;
        end
        return r;
    endfunction

    // ---- decode -> execute stage boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_p0        <= '0;
            rd2_p0        <= '0;
            imm_p0        <= '0;
            rs_p0         <= '0;
            rt_p0         <= '0;
            rd_p0         <= '0;
            alucontrol_p0 <= '0;
            alusrc_p0     <= 1'b0;
            regdst_p0     <= 1'b0;
            regwrite_p0   <= 1'b0;
            memtoreg_p0   <= 1'b0;
            memwrite_p0   <= 1'b0;
            vld_p0        <= 1'b0;
        end else if (flush) begin
            // Bubble: kill the side effects, leave the data fields alone.
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            memtoreg_p0 <= 1'b0;
            memwrite_p0 <= 1'b0;
        end else if (!stall) begin
            rd1_p0        <= rd1_in;
            rd2_p0        <= rd2_in;
            imm_p0        <= imm_in;
            rs_p0         <= rs_in;
            rt_p0         <= rt_in;
            rd_p0         <= rd_in;
            alucontrol_p0 <= alucontrol_in;
            alusrc_p0     <= alusrc_in;
            regdst_p0     <= regdst_in;
            regwrite_p0   <= regwrite_in & valid_in;
            memtoreg_p0   <= memtoreg_in & valid_in;
            memwrite_p0   <= memwrite_in & valid_in;
            vld_p0        <= valid_in;
        end
    end

    always_comb begin
        fwd_rs = fwd_sel(rs_p0, rd1_p0, exm_regwrite, exm_rd, exm_result,
                         mwb_regwrite, mwb_rd, mwb_result);
        fwd_rt = fwd_sel(rt_p0, rd2_p0, exm_regwrite, exm_rd, exm_result,
                         mwb_regwrite, mwb_rd, mwb_result);
    end

    assign srca         = fwd_rs;
    assign writedata    = fwd_rt;
    assign srcb         = alusrc_p0 ? imm_p0 : fwd_rt;
    assign alu_f        = alucontrol_p0;
    assign writereg     = regdst_p0 ? rd_p0 : rt_p0;
    assign regwrite_out = regwrite_p0;
    assign memtoreg_out = memtoreg_p0;
    assign memwrite_out = memwrite_p0;
    assign valid_out    = vld_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a forwarding build and a FWD_EN=0
// build share the same stimulus; expected outputs are queued when stimulus
// is applied and compared once the DUT has produced them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid_in;
    logic [31:0] rd1_in, rd2_in, imm_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [3:0]  alucontrol_in;
    logic        alusrc_in, regdst_in, regwrite_in, memtoreg_in, memwrite_in;
    logic        exm_regwrite, mwb_regwrite;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;

    logic [31:0] srca, srcb, writedata;
    logic [3:0]  alu_f;
    logic [4:0]  writereg;
    logic        regwrite_out, memtoreg_out, memwrite_out, valid_out;

    logic [31:0] srca0, srcb0, writedata0;
    logic [3:0]  alu_f0;
    logic [4:0]  writereg0;
    logic        regwrite_out0, memtoreg_out0, memwrite_out0, valid_out0;

    always #5 clk = ~clk;

    id_ex_stage #(.FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .alucontrol_in(alucontrol_in),
        .alusrc_in(alusrc_in), .regdst_in(regdst_in), .regwrite_in(regwrite_in),
        .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .srca(srca), .srcb(srcb), .alu_f(alu_f), .writedata(writedata),
        .writereg(writereg), .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
        .memwrite_out(memwrite_out), .valid_out(valid_out)
    );

    id_ex_stage #(.FWD_EN(0)) dut_nofwd (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .alucontrol_in(alucontrol_in),
        .alusrc_in(alusrc_in), .regdst_in(regdst_in), .regwrite_in(regwrite_in),
        .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .srca(srca0), .srcb(srcb0), .alu_f(alu_f0), .writedata(writedata0),
        .writereg(writereg0), .regwrite_out(regwrite_out0), .memtoreg_out(memtoreg_out0),
        .memwrite_out(memwrite_out0), .valid_out(valid_out0)
    );

    typedef struct {
        logic [31:0] srca, srcb, wd, srca0;
        logic [3:0]  f;
        logic [4:0]  wr;
        logic        rw, mr, mw, v;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // reference model of the stage registers
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [3:0]  m_alu;
    logic        m_alusrc, m_regdst, m_rw, m_mr, m_mw, m_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] v);
        if (r == 5'd0) return v;
        if (exm_regwrite && exm_rd == r) return exm_result;
        if (mwb_regwrite && mwb_rd == r) return mwb_result;
        return v;
    endfunction

    task automatic model_reset();
        {m_rd1, m_rd2, m_imm} = '0;
        {m_rs, m_rt, m_rd, m_alu} = '0;
        {m_alusrc, m_regdst, m_rw, m_mr, m_mw, m_v} = '0;
    endtask

    task automatic model_clock();
        if (flush) begin
            m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (!stall) begin
            m_rd1 = rd1_in; m_rd2 = rd2_in; m_imm = imm_in;
            m_rs = rs_in; m_rt = rt_in; m_rd = rd_in; m_alu = alucontrol_in;
            m_alusrc = alusrc_in; m_regdst = regdst_in; m_v = valid_in;
            m_rw = valid_in ? regwrite_in : 1'b0;
            m_mr = valid_in ? memtoreg_in : 1'b0;
            m_mw = valid_in ? memwrite_in : 1'b0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.srca  = ref_fwd(m_rs, m_rd1);
        e.wd    = ref_fwd(m_rt, m_rd2);
        e.srcb  = m_alusrc ? m_imm : e.wd;
        e.srca0 = m_rd1;
        e.f  = m_alu;
        e.wr = m_regdst ? m_rd : m_rt;
        e.rw = m_rw; e.mr = m_mr; e.mw = m_mw; e.v = m_v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".srca"},     srca,         e.srca);
        chk({tag, ".srcb"},     srcb,         e.srcb);
        chk({tag, ".wdata"},    writedata,    e.wd);
        chk({tag, ".alu_f"},    {28'd0, alu_f},    {28'd0, e.f});
        chk({tag, ".wreg"},     {27'd0, writereg}, {27'd0, e.wr});
        chk({tag, ".regwrite"}, {31'd0, regwrite_out}, {31'd0, e.rw});
        chk({tag, ".memtoreg"}, {31'd0, memtoreg_out}, {31'd0, e.mr});
        chk({tag, ".memwrite"}, {31'd0, memwrite_out}, {31'd0, e.mw});
        chk({tag, ".valid"},    {31'd0, valid_out},    {31'd0, e.v});
        chk({tag, ".srca_nofwd"}, srca0, e.srca0);
    endtask

    // one clock edge: model update, expectation queued, DUT compared after edge
    task automatic step(input string tag);
        model_clock();
        push_exp();
        @(posedge clk);
        #1;
        pop_cmp(tag);
    endtask

    // combinational re-check after changing only forwarding inputs
    task automatic settle(input string tag);
        push_exp();
        #1;
        pop_cmp(tag);
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; valid_in = 0;
        rd1_in = 0; rd2_in = 0; imm_in = 0; rs_in = 0; rt_in = 0; rd_in = 0;
        alucontrol_in = 0; alusrc_in = 0; regdst_in = 0;
        regwrite_in = 0; memtoreg_in = 0; memwrite_in = 0;
        // forwarding sources aimed at register 0 must not leak during reset
        exm_regwrite = 1; exm_rd = 0; exm_result = 32'hDEAD_BEEF;
        mwb_regwrite = 1; mwb_rd = 0; mwb_result = 32'hFEED_F00D;
        model_reset();
        #3;
        settle("reset");

        @(negedge clk);
        rst_n = 1;
        valid_in = 1; rd1_in = 5; rs_in = 3; rt_in = 4; rd2_in = 9; rd_in = 6;
        regwrite_in = 1; alucontrol_in = 4'hA; regdst_in = 1;
        exm_regwrite = 0; mwb_regwrite = 0;
        step("first_capture");

        // EX/MEM wins over MEM/WB; then MEM/WB alone
        rs_in = 7; rd1_in = 32'h11;
        exm_regwrite = 1; exm_rd = 7; exm_result = 32'hAAAA_0000;
        mwb_regwrite = 1; mwb_rd = 7; mwb_result = 32'h5555_0000;
        step("prio_exm");
        exm_regwrite = 0;
        settle("prio_mwb");

        // register 0 never forwarded
        rt_in = 0; rd2_in = 32'h1234; regdst_in = 0;
        exm_regwrite = 1; exm_rd = 0; mwb_rd = 0;
        step("reg0");
        // immediate selects srcb while writedata still forwards rt
        alusrc_in = 1; imm_in = 32'hFFFF_FFFC; rt_in = 7; exm_rd = 7; memwrite_in = 1;
        step("imm");

        // stall for 3 cycles while inputs change
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rd1_in = $urandom; rd2_in = $urandom; rs_in = 5'(i + 10); alucontrol_in = 4'(i);
            step("stall");
        end
        flush = 1;
        step("flush_stall");
        flush = 0; stall = 0;

        // bubble: write controls suppressed
        valid_in = 0; regwrite_in = 1; memwrite_in = 1; memtoreg_in = 1;
        step("bubble");

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            valid_in = 1'($urandom); stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
            rs_in = 5'($urandom_range(0, 3)); rt_in = 5'($urandom_range(0, 3));
            rd_in = 5'($urandom); alucontrol_in = 4'($urandom);
            {alusrc_in, regdst_in, regwrite_in, memtoreg_in, memwrite_in} = 5'($urandom);
            exm_regwrite = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
            mwb_regwrite = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_result = $urandom;
            step("rand");
        end

        // reset asserted mid-stall discards the held instruction
        flush = 0; stall = 0; valid_in = 1; regwrite_in = 1; rd1_in = 32'h77; rs_in = 9;
        step("pre_stall");
        stall = 1;
        step("held");
        #2;
        rst_n = 0;
        model_reset();
        settle("reset_mid");
        @(negedge clk);
        rst_n = 1; stall = 0;
        rd1_in = 32'h42; rs_in = 3; exm_regwrite = 0; mwb_regwrite = 0;
        step("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
